gpio_debounce_ctrl: RTL and testbench

//   Parametrised N-channel debounced input controller; successor to the single-button debounce/reset FSM.

---
 rtl/gpio_debounce_ctrl.sv | 171 +++++++++++++++++
 tb/tb_gpio_debounce_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_ctrl.sv
// N-channel debounced button/GPIO controller with sticky press/release events,
// a long-press reset request and a small memory-mapped register file.
module gpio_debounce_ctrl #(
  parameter int NUM_CH            = 8,
  parameter int DEBOUNCE_CYCLES   = 65536,
  parameter int LONG_PRESS_CYCLES = 4194304,
  parameter int RESET_CH          = 0,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  input  logic              ren,
  input  logic              wen,
  input  logic [7:0]        address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              irq,
  output logic              reset_req
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [NUM_CH-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  localparam logic [5:0] A_STATE = 6'h00;
  localparam logic [5:0] A_PRESS = 6'h01;
  localparam logic [5:0] A_REL   = 6'h02;
  localparam logic [5:0] A_IRQEN = 6'h03;
  localparam logic [5:0] A_LONG  = 6'h04;
  localparam logic [5:0] A_RAW   = 6'h05;

  logic [NUM_CH-1:0] sync1_r;
  logic [NUM_CH-1:0] sync2_r;
  logic [NUM_CH-1:0] raw_s;
  logic [NUM_CH-1:0] stable_r;
  logic [NUM_CH-1:0] qual_s;
  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] fall_s;
  logic [NUM_CH-1:0] press_pend_r;
  logic [NUM_CH-1:0] rel_pend_r;
  logic [NUM_CH-1:0] irq_en_r;
  logic [NUM_CH-1:0] wr_data_s;
  logic [NUM_CH-1:0] press_clr_s;
  logic [NUM_CH-1:0] rel_clr_s;
  logic              en_wr_s;
  logic              long_clr_s;
  logic              long_set_s;
  logic              long_r;
  logic [DW-1:0]     db_cnt_r [NUM_CH];
  logic [LW-1:0]     lp_cnt_r;
  logic [31:0]       rd_data_s;
  logic              unused_ok_s;

  // Two-flop synchroniser holding raw pin levels; reset to the idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  assign raw_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

  // A channel qualifies when it has differed for the full debounce window.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      qual_s[ch] = (raw_s[ch] != stable_r[ch]) && (db_cnt_r[ch] == DB_LAST);
    end
    rise_s = qual_s & raw_s;
    fall_s = qual_s & ~raw_s;
  end

  // Per-channel debounce counters and accepted levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r <= {NUM_CH{1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) begin
        db_cnt_r[ch] <= {DW{1'b0}};
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (raw_s[ch] == stable_r[ch]) begin
          db_cnt_r[ch] <= {DW{1'b0}};
        end else if (qual_s[ch]) begin
          stable_r[ch] <= raw_s[ch];
          db_cnt_r[ch] <= {DW{1'b0}};
        end else begin
          db_cnt_r[ch] <= db_cnt_r[ch] + DW'(1);
        end
      end
    end
  end

  // Write decode; wen is folded into the selector so idle cycles hit default.
  always_comb begin
    wr_data_s   = data_in[NUM_CH-1:0];
    press_clr_s = {NUM_CH{1'b0}};
    rel_clr_s   = {NUM_CH{1'b0}};
    en_wr_s     = 1'b0;
    long_clr_s  = 1'b0;
    case ({wen, address[7:2]})
      {1'b1, A_PRESS}: press_clr_s = wr_data_s;
      {1'b1, A_REL}:   rel_clr_s   = wr_data_s;
      {1'b1, A_IRQEN}: en_wr_s     = 1'b1;
      {1'b1, A_LONG}:  long_clr_s  = data_in[0];
      default:         en_wr_s     = 1'b0;
    endcase
  end

  // Sticky event bits (a new edge beats a simultaneous clear), mask and irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_pend_r <= {NUM_CH{1'b0}};
      rel_pend_r   <= {NUM_CH{1'b0}};
      irq_en_r     <= {NUM_CH{1'b0}};
      irq          <= 1'b0;
    end else begin
      press_pend_r <= (press_pend_r & ~press_clr_s) | rise_s;
      rel_pend_r   <= (rel_pend_r & ~rel_clr_s) | fall_s;
      irq_en_r     <= en_wr_s ? wr_data_s : irq_en_r;
      irq          <= |((press_pend_r | rel_pend_r) & irq_en_r);
    end
  end

  assign long_set_s = stable_r[RESET_CH] && (lp_cnt_r == LP_LAST) && !reset_req;

  // Saturating long-press timer; LONG latches only on the first expiry of a hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp_cnt_r  <= {LW{1'b0}};
      reset_req <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      if (stable_r[RESET_CH]) begin
        if (lp_cnt_r == LP_LAST) begin
          reset_req <= 1'b1;
        end else begin
          lp_cnt_r <= lp_cnt_r + LW'(1);
        end
      end else begin
        lp_cnt_r  <= {LW{1'b0}};
        reset_req <= 1'b0;
      end
      long_r <= (long_r & ~long_clr_s) | long_set_s;
    end
  end

  // Zero-wait read mux; unmapped offsets read zero.
  always_comb begin
    rd_data_s = 32'h0;
    case (address[7:2])
      A_STATE: rd_data_s[NUM_CH-1:0] = stable_r;
      A_PRESS: rd_data_s[NUM_CH-1:0] = press_pend_r;
      A_REL:   rd_data_s[NUM_CH-1:0] = rel_pend_r;
      A_IRQEN: rd_data_s[NUM_CH-1:0] = irq_en_r;
      A_LONG:  rd_data_s[0]          = long_r;
      A_RAW:   rd_data_s[NUM_CH-1:0] = raw_s;
      default: rd_data_s = 32'h0;
    endcase
  end

  assign data_out    = ren ? rd_data_s : 32'h0;
  assign unused_ok_s = ^{address[1:0], data_in};

endmodule

// File: tb/tb_gpio_debounce_ctrl.sv
// Bench for gpio_debounce_ctrl: directed scenarios with fixed expectations plus a
// randomized run compared against a sample-history reference model.
module tb_gpio_debounce_ctrl;
  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  btn_in = 4'hF;
  logic          ren = 1'b0;
  logic          wen = 1'b0;
  logic [7:0]    address = 8'h00;
  logic [31:0]   data_in = 32'h0;
  logic [31:0]   data_out;
  logic          irq;
  logic          reset_req;
  int            total = 0;
  int            bad = 0;

  gpio_debounce_ctrl #(
    .NUM_CH(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .RESET_CH(0), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .ren(ren), .wen(wen), .address(address),
    .data_in(data_in), .data_out(data_out), .irq(irq), .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  // Reference model: raw_hist holds the synchronised level seen before each edge.
  logic [N-1:0] pin_q[$];
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] m_raw, m_stable, m_pp, m_rp, m_en;
  logic         m_long, m_irq, m_req;
  int           cyc, rise0;

  task automatic model_clear();
    pin_q.delete();
    raw_hist.delete();
    m_raw = '0; m_stable = '0; m_pp = '0; m_rp = '0; m_en = '0;
    m_long = 1'b0; m_irq = 1'b0; m_req = 1'b0;
    cyc = 0; rise0 = 0;
  endtask

  task automatic step();
    logic [N-1:0] pre_stable, pre_pp, pre_rp, pre_en, flip, rises, falls, clr_p, clr_r;
    logic         pre_long, long_set, long_clr, all_diff;
    pre_stable = m_stable; pre_pp = m_pp; pre_rp = m_rp; pre_en = m_en; pre_long = m_long;
    @(posedge clk);
    cyc++;
    raw_hist.push_back(m_raw);
    if (raw_hist.size() > D) void'(raw_hist.pop_front());
    flip = '0;
    if (raw_hist.size() == D) begin
      for (int ch = 0; ch < N; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (raw_hist[k][ch] == pre_stable[ch]) all_diff = 1'b0;
        flip[ch] = all_diff;
      end
    end
    m_stable = pre_stable ^ flip;
    rises = flip & m_stable;
    falls = flip & ~m_stable;
    clr_p = (wen && address == 8'h04) ? data_in[N-1:0] : '0;
    clr_r = (wen && address == 8'h08) ? data_in[N-1:0] : '0;
    long_clr = wen && address == 8'h10 && data_in[0];
    m_pp = (pre_pp & ~clr_p) | rises;
    m_rp = (pre_rp & ~clr_r) | falls;
    if (wen && address == 8'h0C) m_en = data_in[N-1:0];
    m_irq = |((pre_pp | pre_rp) & pre_en);
    m_req = pre_stable[0] && (cyc - rise0 >= L);
    long_set = pre_stable[0] && (cyc - rise0 == L);
    m_long = (pre_long & ~long_clr) | long_set;
    if (rises[0]) rise0 = cyc;
    pin_q.push_back(~btn_in);
    if (pin_q.size() > 2) void'(pin_q.pop_front());
    m_raw = (pin_q.size() == 2) ? pin_q[0] : '0;
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    address = a; ren = 1'b1;
    #1;
    d = data_out; ren = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    address = a; data_in = d; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    btn_in = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", reset_req); end
    for (int a = 0; a < 6; a++) begin
      rd(8'(a * 4), d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
    btn_in = 4'hF;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_press_latency();
    logic [31:0] d;
    int n;
    btn_in = 4'hF; do_reset();
    btn_in = 4'b1011;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      rd(8'h00, d);
      if (d[3:0] != 4'h0) break;
    end
    total++; if (n !== 6) begin bad++; $display("FAIL press_latency: got %0d want 6", n); end
    total++; if (d !== 32'h4) begin bad++; $display("FAIL press_state: got %h want 4", d); end
    rd(8'h04, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL press_pend: got %h want 4", d); end
    rd(8'h08, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL press_rel: got %h want 0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_irq: got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    btn_in = 4'hF; do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        btn_in[1] = (i == 3);
        step();
        rd(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_state: got %h want 0", d); end
      end
    end
    rd(8'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_pend: got %h want 0", d); end
  endtask

  task automatic test_irq_w1c();
    logic [31:0] d;
    btn_in = 4'hF; do_reset();
    wr(8'h0C, 32'hF);
    btn_in[3] = 1'b0; repeat (7) step();
    btn_in[3] = 1'b1; repeat (8) step();
    rd(8'h04, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL irq_press: got %h want 8", d); end
    rd(8'h08, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL irq_rel: got %h want 8", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
    wr(8'h04, 32'h8);
    wr(8'h08, 32'h8);
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    rd(8'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_press: got %h want 0", d); end
    btn_in[3] = 1'b0; repeat (5) step();
    wr(8'h04, 32'h8);
    rd(8'h04, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL set_wins: got %h want 8", d); end
    wr(8'h04, 32'h8);
    rd(8'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_after: got %h want 0", d); end
  endtask

  task automatic test_long_press();
    logic [31:0] d;
    int n;
    btn_in = 4'hF; do_reset();
    btn_in[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); rd(8'h00, d); if (d[0]) break; end
    n = 0;
    for (int i = 0; i < 40; i++) begin step(); n++; if (reset_req) break; end
    total++; if (n !== 16) begin bad++; $display("FAIL long_latency: got %0d want 16", n); end
    rd(8'h10, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL long_bit: got %h want 1", d); end
    btn_in[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin step(); n++; if (!reset_req) break; end
    total++; if (n !== 7) begin bad++; $display("FAIL long_release: got %0d want 7", n); end
    rd(8'h10, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL long_sticky: got %h want 1", d); end
    wr(8'h10, 32'h1);
    rd(8'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL long_w1c: got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n;
    btn_in = 4'hF; do_reset();
    wr(8'h0C, 32'h1);
    btn_in[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); rd(8'h00, d); if (d[0]) break; end
    repeat (10) step();
    reset = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq: got %b want 0", irq); end
    total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", reset_req); end
    rd(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_state: got %h want 0", d); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    n = 0;
    for (int i = 0; i < 20; i++) begin step(); n++; rd(8'h00, d); if (d[0]) break; end
    total++; if (n !== 6) begin bad++; $display("FAIL mid_requal: got %0d want 6", n); end
    for (int i = 0; i < 40; i++) begin if (reset_req) break; step(); n++; end
    total++; if (n !== 22) begin bad++; $display("FAIL mid_long: got %0d want 22", n); end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    btn_in = 4'hF; do_reset();
    btn_in[1] = 1'b0; repeat (7) step();
    rd(8'h18, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bus_18: got %h want 0", d); end
    rd(8'h1C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bus_1c: got %h want 0", d); end
    wr(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL bus_ro: got %h want 2", d); end
    address = 8'h00; ren = 1'b0;
    #1;
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL bus_noren: got %h want 0", data_out); end
    address = 8'h0C; data_in = 32'h5; wen = 1'b1; ren = 1'b1;
    #1;
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL bus_rw_pre: got %h want 0", data_out); end
    step();
    wen = 1'b0; ren = 1'b0;
    rd(8'h0C, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL bus_rw_post: got %h want 5", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    btn_in = 4'hF; do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, (ch == 0) ? 39 : 5) == 0) btn_in[ch] = ~btn_in[ch];
      end
      if ($urandom_range(0, 3) == 0) begin
        wen = 1'b1; data_in = $urandom;
        case ($urandom_range(0, 4))
          0: address = 8'h04;
          1: address = 8'h08;
          2: address = 8'h0C;
          3: address = 8'h10;
          default: address = 8'h00;
        endcase
      end
      step();
      wen = 1'b0;
      rd(8'h00, d);
      total++; if (d !== {28'h0, m_stable}) begin bad++; $display("FAIL rnd_state@%0d: got %h want %h", i, d, m_stable); end
      rd(8'h04, d);
      total++; if (d !== {28'h0, m_pp}) begin bad++; $display("FAIL rnd_press@%0d: got %h want %h", i, d, m_pp); end
      rd(8'h08, d);
      total++; if (d !== {28'h0, m_rp}) begin bad++; $display("FAIL rnd_rel@%0d: got %h want %h", i, d, m_rp); end
      rd(8'h0C, d);
      total++; if (d !== {28'h0, m_en}) begin bad++; $display("FAIL rnd_en@%0d: got %h want %h", i, d, m_en); end
      rd(8'h10, d);
      total++; if (d !== {31'h0, m_long}) begin bad++; $display("FAIL rnd_long@%0d: got %h want %h", i, d, m_long); end
      rd(8'h14, d);
      total++; if (d !== {28'h0, m_raw}) begin bad++; $display("FAIL rnd_raw@%0d: got %h want %h", i, d, m_raw); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq@%0d: got %b want %b", i, irq, m_irq); end
      total++; if (reset_req !== m_req) begin bad++; $display("FAIL rnd_req@%0d: got %b want %b", i, reset_req, m_req); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_press_latency();
    test_glitch();
    test_irq_w1c();
    test_long_press();
    test_reset_mid();
    test_bus();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
